// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshake, x86-style flags and an
// iterative shift-add multiplier. Single-cycle ops complete at the accepting edge.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] input_x,
    input  logic [WIDTH-1:0] input_y,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_b,
    output logic             CF,
    output logic             AF,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_INC = 4'h2, OP_DEC = 4'h3,
                           OP_ADC = 4'h4, OP_SBB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                           OP_XOR = 4'h8, OP_NOT = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
                           OP_SAR = 4'hC, OP_MUL = 4'hD, OP_CMP = 4'hE, OP_PASS = 4'hF;

    typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

    // Returns {cf, af, of, result}; cf is borrow for subtraction.
    function automatic logic [WIDTH+2:0] arith(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic             ovf;
        if (sub) begin
            s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        end else begin
            s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end
        r = s[WIDTH-1:0];
        if (sub) begin
            ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (r[WIDTH-1] ^ a[WIDTH-1]);
        end else begin
            ovf = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (r[WIDTH-1] ^ a[WIDTH-1]);
        end
        return {s[WIDTH], a[4] ^ b[4] ^ r[4], ovf, r};
    endfunction

    state_t              state_r, next_state_s;
    logic [CW-1:0]       cnt_r;
    logic [2*WIDTH-1:0]  acc_r, mcand_r, prod_s;
    logic [WIDTH-1:0]    mplier_r;
    logic [WIDTH-1:0]    alu_b_r;
    logic                cf_r, af_r, zf_r, sf_r, of_r, out_valid_r;

    logic [WIDTH-1:0]    b_op_s, res_s, fres_s;
    logic                cin_s, sub_s, wr_s, cf_s, af_s, of_s;
    logic [WIDTH+2:0]    ar_s;
    logic                accept_s, mul_done_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: MUL runs WIDTH iterations, finishing on the last one.
    always_comb begin
        next_state_s = state_r;
        accept_s     = in_valid & (state_r == IDLE);
        mul_done_s   = (state_r == MUL) && (cnt_r == LAST);
        case (state_r)
            IDLE: begin
                if (accept_s && (op == OP_MUL)) begin
                    next_state_s = MUL;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = MUL;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Single-cycle result and flags; fres_s is the value ZF/SF are taken from.
    always_comb begin
        b_op_s = input_y;
        cin_s  = 1'b0;
        sub_s  = 1'b0;
        case (op)
            OP_SUB, OP_CMP: sub_s = 1'b1;
            OP_INC:         b_op_s = ONE;
            OP_DEC:         begin b_op_s = ONE; sub_s = 1'b1; end
            OP_ADC:         cin_s = cf_r;
            OP_SBB:         begin cin_s = cf_r; sub_s = 1'b1; end
            default:        b_op_s = input_y;
        endcase
        ar_s = arith(input_x, b_op_s, cin_s, sub_s);

        res_s = ar_s[WIDTH-1:0];
        cf_s  = ar_s[WIDTH+2];
        af_s  = ar_s[WIDTH+1];
        of_s  = ar_s[WIDTH];
        wr_s  = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB: wr_s = 1'b1;
            OP_INC, OP_DEC: cf_s = cf_r;
            OP_CMP:  wr_s = 1'b0;
            OP_AND:  begin res_s = input_x & input_y; {cf_s, af_s, of_s} = 3'b000; end
            OP_OR:   begin res_s = input_x | input_y; {cf_s, af_s, of_s} = 3'b000; end
            OP_XOR:  begin res_s = input_x ^ input_y; {cf_s, af_s, of_s} = 3'b000; end
            OP_NOT:  begin res_s = ~input_x;          {cf_s, af_s, of_s} = 3'b000; end
            OP_PASS: begin res_s = input_y;           {cf_s, af_s, of_s} = 3'b000; end
            OP_SHL: begin
                res_s = {input_x[WIDTH-2:0], 1'b0};
                cf_s  = input_x[WIDTH-1];
                af_s  = 1'b0;
                of_s  = input_x[WIDTH-2] ^ input_x[WIDTH-1];
            end
            OP_SHR: begin
                res_s = {1'b0, input_x[WIDTH-1:1]};
                cf_s  = input_x[0];
                af_s  = 1'b0;
                of_s  = input_x[WIDTH-1];
            end
            OP_SAR: begin
                res_s = {input_x[WIDTH-1], input_x[WIDTH-1:1]};
                cf_s  = input_x[0];
                af_s  = 1'b0;
                of_s  = 1'b0;
            end
            default: wr_s = 1'b1;
        endcase
        fres_s = res_s;
        prod_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            mcand_r     <= {(2*WIDTH){1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            alu_b_r     <= {WIDTH{1'b0}};
            {cf_r, af_r, zf_r, sf_r, of_r} <= 5'b00000;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (state_r == MUL) begin
                acc_r    <= prod_s;
                mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (mul_done_s) begin
                    alu_b_r     <= prod_s[WIDTH-1:0];
                    cf_r        <= |prod_s[2*WIDTH-1:WIDTH];
                    of_r        <= |prod_s[2*WIDTH-1:WIDTH];
                    af_r        <= 1'b0;
                    zf_r        <= (prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    sf_r        <= prod_s[WIDTH-1];
                    out_valid_r <= 1'b1;
                end
            end else if (accept_s) begin
                if (op == OP_MUL) begin
                    cnt_r    <= {CW{1'b0}};
                    acc_r    <= {(2*WIDTH){1'b0}};
                    mcand_r  <= {{WIDTH{1'b0}}, input_x};
                    mplier_r <= input_y;
                end else begin
                    if (wr_s) begin
                        alu_b_r <= res_s;
                    end
                    cf_r        <= cf_s;
                    af_r        <= af_s;
                    of_r        <= of_s;
                    zf_r        <= (fres_s == {WIDTH{1'b0}});
                    sf_r        <= fres_s[WIDTH-1];
                    out_valid_r <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r == MUL);
    assign out_valid = out_valid_r;
    assign alu_b     = alu_b_r;
    assign CF        = cf_r;
    assign AF        = af_r;
    assign ZF        = zf_r;
    assign SF        = sf_r;
    assign OF        = of_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8); flags compared as {CF,AF,ZF,SF,OF}.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'h0;
    logic [7:0] input_x = 8'h00, input_y = 8'h00;
    logic       out_valid;
    logic [7:0] alu_b;
    logic       CF, AF, ZF, SF, OF, busy;

    int n_total = 0;
    int n_pass  = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .input_x(input_x), .input_y(input_y), .out_valid(out_valid),
        .alu_b(alu_b), .CF(CF), .AF(AF), .ZF(ZF), .SF(SF), .OF(OF), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {CF, AF, ZF, SF, OF};
    endfunction

    // One single-cycle op: drive on negedge, sample 1 ns after the accepting edge.
    task automatic op_chk(input string tag, input logic [3:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] exp_b, input logic [4:0] exp_f);
        @(negedge clk);
        op = o; input_x = x; input_y = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".b"}, {24'd0, alu_b}, {24'd0, exp_b});
        check({tag, ".flags"}, {27'd0, flags()}, {27'd0, exp_f});
    endtask

    initial begin
        int lat;
        int ready_lo;
        int pulses;

        repeat (3) @(posedge clk);
        #1;
        check("rst.b", {24'd0, alu_b}, 32'd0);
        check("rst.flags", {27'd0, flags()}, 32'd0);
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.ready", {31'd0, in_ready}, 32'd1);
        check("rst.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //                 op     x      y      b      CF AF ZF SF OF
        op_chk("add1",  4'h0, 8'hF5, 8'hF5, 8'hEA, 5'b10010);
        op_chk("add2",  4'h0, 8'h7F, 8'h01, 8'h80, 5'b01011);
        op_chk("adc0",  4'h4, 8'h01, 8'h01, 8'h02, 5'b00000);
        op_chk("sub1",  4'h1, 8'h00, 8'h01, 8'hFF, 5'b11010);
        op_chk("adc1",  4'h4, 8'h01, 8'h01, 8'h03, 5'b00000);
        op_chk("inc0",  4'h2, 8'hFF, 8'h00, 8'h00, 5'b01100);
        op_chk("sub2",  4'h1, 8'h00, 8'h01, 8'hFF, 5'b11010);
        op_chk("inc1",  4'h2, 8'hFF, 8'h00, 8'h00, 5'b11100);
        op_chk("dec",   4'h3, 8'h00, 8'h00, 8'hFF, 5'b11010);
        op_chk("sbb",   4'h5, 8'h05, 8'h02, 8'h02, 5'b00000);
        op_chk("and",   4'h6, 8'hF0, 8'h3C, 8'h30, 5'b00000);
        op_chk("or",    4'h7, 8'h0F, 8'h80, 8'h8F, 5'b00010);
        op_chk("xor",   4'h8, 8'hAA, 8'hAA, 8'h00, 5'b00100);
        op_chk("not",   4'h9, 8'h00, 8'h33, 8'hFF, 5'b00010);
        op_chk("shl",   4'hA, 8'h80, 8'h00, 8'h00, 5'b10101);
        op_chk("shr",   4'hB, 8'h81, 8'h00, 8'h40, 5'b10001);
        op_chk("sar",   4'hC, 8'h81, 8'h00, 8'hC0, 5'b10010);
        op_chk("pass",  4'hF, 8'h55, 8'h5A, 8'h5A, 5'b00000);
        op_chk("cmpeq", 4'hE, 8'h05, 8'h05, 8'h5A, 5'b00100);
        op_chk("cmplt", 4'hE, 8'h03, 8'h05, 8'h5A, 5'b11010);

        @(posedge clk);
        #1;
        check("idle.valid", {31'd0, out_valid}, 32'd0);
        check("idle.b", {24'd0, alu_b}, 32'h5A);

        // MUL with in_valid held high (different op) while busy.
        @(negedge clk);
        op = 4'hD; input_x = 8'h10; input_y = 8'h20; in_valid = 1'b1;
        lat = 0;
        ready_lo = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!in_ready) ready_lo++;
            if (lat == 1) begin
                op = 4'h0; input_x = 8'h01; input_y = 8'h01;
            end
            if (lat == 8) in_valid = 1'b0;
        end while (!out_valid && lat < 20);
        check("mul.lat", lat, 32'd9);
        check("mul.ready_lo", ready_lo, 32'd8);
        check("mul.b", {24'd0, alu_b}, 32'h00);
        check("mul.flags", {27'd0, flags()}, {27'd0, 5'b10101});
        check("mul.ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("mul.after_valid", {31'd0, out_valid}, 32'd0);
        check("mul.after_b", {24'd0, alu_b}, 32'h00);

        // Reset three cycles into a MUL.
        @(negedge clk);
        op = 4'hD; input_x = 8'hFF; input_y = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mulr.busy", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstm.b", {24'd0, alu_b}, 32'd0);
        check("rstm.flags", {27'd0, flags()}, 32'd0);
        check("rstm.busy", {31'd0, busy}, 32'd0);
        check("rstm.ready", {31'd0, in_ready}, 32'd1);
        pulses = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("rstm.pulses", pulses, 32'd0);
        check("rstm.ready_after", {31'd0, in_ready}, 32'd1);
        op_chk("post", 4'h0, 8'h02, 8'h03, 8'h05, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
